// File: rtl/ram_cmd_arbiter.sv
// Round-robin share of one command-driven single-port RAM between two requesters.
// Each granted transaction becomes two RAM command words; the result returns to its owner.
module ram_cmd_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic                 req0_we,
    input  logic [ADDR_SIZE-1:0] req0_addr,
    input  logic [ADDR_SIZE-1:0] req0_wdata,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic                 req1_we,
    input  logic [ADDR_SIZE-1:0] req1_addr,
    input  logic [ADDR_SIZE-1:0] req1_wdata,
    output logic                 req1_ready,
    output logic                 rsp0_valid,
    output logic [ADDR_SIZE-1:0] rsp0_rdata,
    output logic                 rsp0_err,
    output logic                 rsp1_valid,
    output logic [ADDR_SIZE-1:0] rsp1_rdata,
    output logic                 rsp1_err,
    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic                 ram_tx_valid,
    input  logic [ADDR_SIZE-1:0] ram_dout,
    output logic                 busy
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD_ADDR,
        CMD_DATA,
        WAIT_RD,
        RESP
    } state_t;

    typedef struct packed {
        logic                 id;
        logic                 we;
        logic [ADDR_SIZE-1:0] addr;
        logic [ADDR_SIZE-1:0] wdata;
    } txn_t;

    state_t               state_q, state_d;
    txn_t                 txn_q, txn_d, sel;
    logic                 last_grant_q, last_grant_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [ADDR_SIZE-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [ADDR_SIZE+1:0] din_q, din_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 gnt0, gnt1;

    // On contention the requester not served last wins; a lone requester always wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && state_q == IDLE) begin
            gnt0 = req0_valid && (!req1_valid || last_grant_q);
            gnt1 = req1_valid && (!req0_valid || !last_grant_q);
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        sel = gnt1 ? {1'b1, req1_we, req1_addr, req1_wdata}
                   : {1'b0, req0_we, req0_addr, req0_wdata};
    end

    always_comb begin
        state_d      = state_q;
        txn_d        = txn_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        din_d        = din_q;
        rx_valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    txn_d        = sel;
                    last_grant_d = gnt1;
                    rdata_d      = '0;
                    err_d        = 1'b0;
                    rx_valid_d   = 1'b1;
                    din_d        = {(sel.we ? 2'b00 : 2'b10), sel.addr};
                    state_d      = CMD_ADDR;
                end
            end
            CMD_ADDR: begin
                rx_valid_d = 1'b1;
                din_d      = {(txn_q.we ? 2'b01 : 2'b11),
                              (txn_q.we ? txn_q.wdata : {ADDR_SIZE{1'b0}})};
                state_d    = CMD_DATA;
            end
            CMD_DATA: begin
                cnt_d   = '0;
                state_d = txn_q.we ? RESP : WAIT_RD;
            end
            WAIT_RD: begin
                if (ram_tx_valid) begin
                    rdata_d = ram_dout;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    // RAM never answered: report an error with zero data.
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            txn_q        <= '0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            din_q        <= '0;
            rx_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            txn_q        <= txn_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            din_q        <= din_d;
            rx_valid_q   <= rx_valid_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign ram_din      = din_q;
    assign ram_rx_valid = rx_valid_q;

    assign rsp0_valid = (state_q == RESP) && !txn_q.id;
    assign rsp1_valid = (state_q == RESP) &&  txn_q.id;
    assign rsp0_rdata = rsp0_valid ? rdata_q : '0;
    assign rsp1_rdata = rsp1_valid ? rdata_q : '0;
    assign rsp0_err   = rsp0_valid && err_q;
    assign rsp1_err   = rsp1_valid && err_q;

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Bench for ram_cmd_arbiter: behavioural RAM, transaction-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_ram_cmd_arbiter;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_we, req0_ready;
    logic [7:0] req0_addr, req0_wdata;
    logic       req1_valid, req1_we, req1_ready;
    logic [7:0] req1_addr, req1_wdata;
    logic       rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [7:0] rsp0_rdata, rsp1_rdata;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic       ram_tx_valid;
    logic [7:0] ram_dout;
    logic       busy;

    ram_cmd_arbiter #(.ADDR_SIZE(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_tx_valid(ram_tx_valid), .ram_dout(ram_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural RAM: the '11' word returns mem[addr]; any other command clears tx_valid.
    logic [7:0] rammem [256];
    logic [7:0] ram_a = 8'h00;
    bit         ram_stall = 1'b0;
    initial begin
        ram_tx_valid = 1'b0;
        ram_dout     = 8'h00;
    end
    always @(posedge clk) begin
        if (ram_rx_valid) begin
            case (ram_din[9:8])
                2'b00, 2'b10: begin ram_a <= ram_din[7:0]; ram_tx_valid <= 1'b0; end
                2'b01:        begin rammem[ram_a] <= ram_din[7:0]; ram_tx_valid <= 1'b0; end
                default: begin
                    if (!ram_stall) begin
                        ram_tx_valid <= 1'b1;
                        ram_dout     <= rammem[ram_a];
                    end else begin
                        ram_tx_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Reference model: one transaction at a time, outputs derived from the cycle
    // offset since acceptance (words at +1/+2, response at +3 write, +4 read, +3+TMO timeout).
    logic [7:0] refmem [256];
    bit         m_inflight = 1'b0;
    bit         m_last = 1'b1;
    int         m_acc = 0, m_off = 0, off;
    bit         m_id, m_we, m_err;
    logic [7:0] m_addr, m_wdata, m_rd;
    logic [9:0] m_din = 10'h000;
    bit         e_g0, e_g1, e_rx, e_rsp;

    initial begin
        for (int i = 0; i < 256; i++) begin
            rammem[i] = 8'h00;
            refmem[i] = 8'h00;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            m_inflight = 1'b0;
            m_last     = 1'b1;
            m_din      = 10'h000;
            chk("rst_ready0", 32'(req0_ready), 32'd0);
            chk("rst_ready1", 32'(req1_ready), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_rx_valid", 32'(ram_rx_valid), 32'd0);
            chk("rst_din", 32'(ram_din), 32'd0);
            chk("rst_rsp0", 32'(rsp0_valid), 32'd0);
            chk("rst_rsp1", 32'(rsp1_valid), 32'd0);
        end else begin
            if (m_inflight && (cyc - m_acc) > m_off) m_inflight = 1'b0;
            off   = cyc - m_acc;
            e_rx  = m_inflight && (off == 1 || off == 2);
            e_rsp = m_inflight && (off == m_off);
            if (m_inflight && off == 1) m_din = {(m_we ? 2'b00 : 2'b10), m_addr};
            if (m_inflight && off == 2) m_din = {(m_we ? 2'b01 : 2'b11), (m_we ? m_wdata : 8'h00)};
            e_g0 = 1'b0;
            e_g1 = 1'b0;
            if (!m_inflight) begin
                e_g0 = req0_valid && (!req1_valid || m_last);
                e_g1 = req1_valid && (!req0_valid || !m_last);
            end
            chk("m_ready0", 32'(req0_ready), 32'(e_g0));
            chk("m_ready1", 32'(req1_ready), 32'(e_g1));
            chk("m_busy", 32'(busy), 32'(m_inflight));
            chk("m_rx_valid", 32'(ram_rx_valid), 32'(e_rx));
            chk("m_din", 32'(ram_din), 32'(m_din));
            chk("m_rsp0_valid", 32'(rsp0_valid), 32'(e_rsp && !m_id));
            chk("m_rsp1_valid", 32'(rsp1_valid), 32'(e_rsp && m_id));
            if (e_rsp && !m_id) begin
                chk("m_rsp0_rdata", 32'(rsp0_rdata), 32'(m_rd));
                chk("m_rsp0_err", 32'(rsp0_err), 32'(m_err));
            end
            if (e_rsp && m_id) begin
                chk("m_rsp1_rdata", 32'(rsp1_rdata), 32'(m_rd));
                chk("m_rsp1_err", 32'(rsp1_err), 32'(m_err));
            end
            if (e_g0 || e_g1) begin
                m_inflight = 1'b1;
                m_acc      = cyc;
                m_id       = e_g1;
                m_last     = e_g1;
                m_we       = e_g1 ? req1_we : req0_we;
                m_addr     = e_g1 ? req1_addr : req0_addr;
                m_wdata    = e_g1 ? req1_wdata : req0_wdata;
                m_err      = !m_we && ram_stall;
                m_off      = m_we ? 3 : (ram_stall ? 3 + TMO : 4);
                m_rd       = (m_we || ram_stall) ? 8'h00 : refmem[m_addr];
                if (m_we) refmem[m_addr] = m_wdata;
            end
        end
    end

    // Present a request, hold it until accepted, then drop it and scramble the fields.
    task automatic issue(input bit id, input bit we, input logic [7:0] a, input logic [7:0] d,
                         output int acc);
        int n;
        @(posedge clk); #1;
        if (!id) begin req0_valid = 1; req0_we = we; req0_addr = a; req0_wdata = d; end
        else     begin req1_valid = 1; req1_we = we; req1_addr = a; req1_wdata = d; end
        acc = -1;
        n = 0;
        while (acc < 0 && n < 64) begin
            @(negedge clk);
            n++;
            if ((!id && req0_ready) || (id && req1_ready)) acc = cyc;
        end
        if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (!id) begin req0_valid = 0; req0_we = !we; req0_addr = ~a; req0_wdata = ~d; end
        else     begin req1_valid = 0; req1_we = !we; req1_addr = ~a; req1_wdata = ~d; end
    endtask

    task automatic wait_rsp(input bit id, input int maxc, output int rc);
        int n;
        rc = -1;
        n = 0;
        while (rc < 0 && n < maxc) begin
            @(negedge clk);
            n++;
            if ((!id && rsp0_valid) || (id && rsp1_valid)) rc = cyc;
        end
        if (rc < 0) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 64);
        if (busy) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    logic [7:0] la [3];
    int         lacc [3];
    int         ord [4];

    initial begin
        int acc, rc, n, k;
        bit got;
        la = '{8'hFF, 8'h00, 8'h7F};
        rst = 1;
        req0_valid = 1; req0_we = 1; req0_addr = 8'h00; req0_wdata = 8'h00;
        req1_valid = 0; req1_we = 0; req1_addr = 8'h00; req1_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready0_held_valid", 32'(req0_ready), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        req0_valid = 0;
        rst = 0;

        // Write 0xA5 to 0x12 from req0.
        issue(0, 1, 8'h12, 8'hA5, acc);
        @(negedge clk);
        chk("wr_word0", 32'(ram_din), 32'h012);
        chk("wr_word0_vld", 32'(ram_rx_valid), 32'd1);
        @(negedge clk);
        chk("wr_word1", 32'(ram_din), 32'h1A5);
        @(negedge clk);
        chk("wr_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("wr_rsp0_rdata", 32'(rsp0_rdata), 32'h00);
        chk("wr_rsp0_err", 32'(rsp0_err), 32'd0);
        chk("wr_latency", 32'(cyc - acc), 32'd3);

        // Read it back.
        issue(0, 0, 8'h12, 8'h00, acc);
        @(negedge clk);
        chk("rd_word0", 32'(ram_din), 32'h212);
        @(negedge clk);
        chk("rd_word1", 32'(ram_din), 32'h300);
        @(negedge clk);
        chk("rd_no_early_rsp", 32'(rsp0_valid), 32'd0);
        @(negedge clk);
        chk("rd_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("rd_rsp0_rdata", 32'(rsp0_rdata), 32'hA5);
        chk("rd_rsp1_quiet", 32'(rsp1_valid), 32'd0);
        chk("rd_latency", 32'(cyc - acc), 32'd4);

        // Lone requester 1: three back-to-back writes of 0xFF, valid held throughout.
        @(posedge clk); #1;
        req1_valid = 1; req1_we = 1; req1_wdata = 8'hFF; req1_addr = la[0];
        for (int i = 0; i < 3; i++) begin
            got = 0;
            n = 0;
            while (!got && n < 40) begin
                @(negedge clk);
                n++;
                if (req1_ready) begin got = 1; lacc[i] = cyc; end
            end
            if (!got) chk("lone_accept_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
            if (i < 2) req1_addr = la[i + 1];
            else       req1_valid = 0;
        end
        chk("lone_gap01", 32'(lacc[1] - lacc[0]), 32'd4);
        chk("lone_gap12", 32'(lacc[2] - lacc[1]), 32'd4);
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            issue(1, 0, la[i], 8'h00, acc);
            wait_rsp(1, 10, rc);
            chk("lone_readback", 32'(rsp1_rdata), 32'hFF);
        end

        // Timeout: RAM never returns data.
        ram_stall = 1;
        issue(0, 0, 8'h12, 8'h00, acc);
        wait_rsp(0, 40, rc);
        chk("tmo_latency", 32'(rc - acc), 32'(3 + TMO));
        chk("tmo_err", 32'(rsp0_err), 32'd1);
        chk("tmo_rdata", 32'(rsp0_rdata), 32'h00);
        wait_idle();
        ram_stall = 0;
        issue(0, 0, 8'h12, 8'h00, acc);
        wait_rsp(0, 10, rc);
        chk("post_tmo_rdata", 32'(rsp0_rdata), 32'hA5);
        chk("post_tmo_err", 32'(rsp0_err), 32'd0);
        chk("post_tmo_latency", 32'(rc - acc), 32'd4);

        // Reset while waiting for read data, then contention from reset.
        ram_stall = 1;
        issue(0, 0, 8'h7F, 8'h00, acc);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rx_valid", 32'(ram_rx_valid), 32'd0);
        chk("mid_rst_din", 32'(ram_din), 32'd0);
        chk("mid_rst_rsp0", 32'(rsp0_valid), 32'd0);
        req0_valid = 1; req0_we = 1; req0_addr = 8'h40; req0_wdata = 8'h11;
        req1_valid = 1; req1_we = 1; req1_addr = 8'h41; req1_wdata = 8'h22;
        #1;
        chk("mid_rst_ready0", 32'(req0_ready), 32'd0);
        chk("mid_rst_ready1", 32'(req1_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        ram_stall = 0;
        #1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_rsp0", 32'(rsp0_valid), 32'd0);
        k = 0;
        n = 0;
        while (k < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (req0_valid && req0_ready)      begin ord[k] = 0; k++; end
            else if (req1_valid && req1_ready) begin ord[k] = 1; k++; end
        end
        if (k < 4) chk("contention_timeout", 32'(k), 32'd4);
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 0;
        wait_idle();
        chk("grant_0", 32'(ord[0]), 32'd0);
        chk("grant_1", 32'(ord[1]), 32'd1);
        chk("grant_2", 32'(ord[2]), 32'd0);
        chk("grant_3", 32'(ord[3]), 32'd1);

        issue(1, 0, 8'h41, 8'h00, acc);
        wait_rsp(1, 10, rc);
        chk("contention_readback", 32'(rsp1_rdata), 32'h22);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/ram_cmd_arbiter.md
Name: ram_cmd_arbiter

Overview:
- Shares one single-port command-driven RAM between two requesters. Each requester issues simple write or read transactions.
- Round-robin arbitration. The block serialises each granted transaction into the RAM's 10-bit two-word command protocol:
  - write: {00,addr} then {01,data}
  - read: {10,addr} then {11,dummy}
- Captures the RAM read response and returns it to the owning requester.
- Sits between the SPI-side/host-side masters and the RAM.

Parameters:
- ADDR_SIZE, 8, width of address and data fields; RAM command word is ADDR_SIZE+2 bits.
- TIMEOUT, 15, max cycles in WAIT_RD before an error response (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- reqN_valid  input  1  (N=0,1) transaction request.
- reqN_we  input  1  1=write, 0=read.
- reqN_addr  input  ADDR_SIZE  target address.
- reqN_wdata  input  ADDR_SIZE  write data (ignored for reads).
- reqN_ready  output  1  request accepted this cycle when valid&&ready.
- rspN_valid  output  1  one-cycle completion pulse.
- rspN_rdata  output  ADDR_SIZE  read data; 0 for writes and errors.
- rspN_err  output  1  valid with rspN_valid; 1 = read timeout.
- ram_din  output  ADDR_SIZE+2  command word to RAM.
- ram_rx_valid  output  1  command word valid.
- ram_tx_valid  input  1  RAM read data valid (sticky until next command).
- ram_dout  input  ADDR_SIZE  RAM read data.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, last_grant=1 (req0 wins first contention), timeout counter 0.
  - All outputs 0: ram_din, ram_rx_valid, rspN_*, busy.
  - reqN_ready = 0 while rst is high.
  - An in-flight transaction is dropped with no response; RAM contents are untouched.
- FSM states: IDLE, CMD_ADDR, CMD_DATA, WAIT_RD, RESP.
- IDLE:
  - reqN_ready is combinational: high only for the arbitration winner.
  - Only req0 valid -> grant 0. Only req1 valid -> grant 1. Both valid -> grant the one != last_grant.
  - On accept, capture we/addr/wdata/id, update last_grant, go to CMD_ADDR.
  - Later changes on the requester's inputs do not affect the transaction.
- CMD_ADDR (1 cycle): ram_rx_valid=1, ram_din={we?2'b00:2'b10, addr}. Go to CMD_DATA.
- CMD_DATA (1 cycle): ram_rx_valid=1, ram_din={we?2'b01:2'b11, we?wdata:0}.
  - Write -> RESP.
  - Read -> WAIT_RD, clear counter.
- WAIT_RD: ram_rx_valid=0.
  - ram_tx_valid=1 -> capture ram_dout, err=0, go to RESP.
  - Otherwise increment counter. Counter reaching TIMEOUT -> err=1, rdata=0, go to RESP.
- RESP (1 cycle): rspN_valid=1 for the captured id only, with rdata/err; other requester's rsp outputs stay 0. Go to IDLE.
- ram_din and ram_rx_valid are registered. ram_rx_valid is 0 outside CMD_ADDR/CMD_DATA; ram_din holds its last value when not valid.
- Latency from the accept edge:
  - write: rsp_valid in 3rd cycle after accept (cycles: ADDR, DATA, RESP).
  - read with nominal RAM: rsp_valid in 4th cycle (ADDR, DATA, WAIT_RD, RESP).
  - Max 1 transaction in flight; throughput: 1 write per 4 cycles, 1 read per 5 cycles.
- Boundaries:
  - Address all-ones and data all-ones pass unmodified.
  - A request held valid while the other requester is serviced waits; no starvation.
  - A lone requester may be granted back-to-back.

Test Plan:
- Write, req0 we=1 addr=0x12 wdata=0xA5: ram_din 0x012 then 0x1A5 (rx_valid 2 cycles) -> rsp0_valid 3rd cycle after accept, rdata=0, err=0.
- Read, req0 we=0 addr=0x12 after the above: ram_din 0x212 then 0x300 -> rsp0_valid 4th cycle after accept, rsp0_rdata=0xA5, rsp1_valid stays 0.
- Contention: req0 and req1 held valid together from reset -> grants in order 0,1,0,1; each rsp on its own port only.
- Lone requester: req1 issues 3 back-to-back writes (addrs 0xFF, 0x00, 0x7F, data 0xFF) -> all granted, read-backs return 0xFF.
- Timeout: RAM model never raises tx_valid on a read -> rsp_valid after TIMEOUT cycles in WAIT_RD, err=1, rdata=0; next request is serviced normally.
- Reset mid-read (rst in WAIT_RD): outputs 0 immediately; after release no rsp pulse, busy=0, req0 wins the first contention.
